// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the two-port data-memory arbiter.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_WORD = 2'b00,
    OP_BYTE = 2'b01,
    OP_HALF = 2'b10,
    OP_ILL  = 2'b11
  } dm_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } dm_state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        port;
  } dm_req_t;

endpackage

// File: rtl/dm_access_check.sv
// Combinational rejection of illegal ops, misaligned and out-of-range accesses.
module dm_access_check
  import dm_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  output logic        err
);

  always_comb begin
    err = (addr >= ADDR_LIMIT);
    case (dm_op_e'(op))
      OP_WORD: if (addr[1:0] != 2'b00) err = 1'b1;
      OP_HALF: if (addr[0]) err = 1'b1;
      OP_BYTE: ;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two requesters.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
  parameter logic        RR_INIT    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [31:0] req0_pc,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [31:0] req1_pc,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        dm_we,
  output logic [1:0]  dm_op,
  output logic [31:0] dm_a,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  dm_state_e   state, state_nx;
  logic        last_grant;
  logic        grant;
  logic        hs;
  logic        acc_err;
  dm_req_t     lat, req_sel;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  dm_access_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_check (
    .op   (lat.op),
    .addr (lat.addr),
    .err  (acc_err)
  );

  // A lone requester wins outright; a tie goes to the port not served last.
  always_comb begin
    if (req0_valid ^ req1_valid) grant = req1_valid;
    else                         grant = ~last_grant;
  end

  always_comb begin
    if (grant) req_sel = '{we: req1_we, op: req1_op, addr: req1_addr,
                           wdata: req1_wdata, pc: req1_pc, port: 1'b1};
    else       req_sel = '{we: req0_we, op: req0_op, addr: req0_addr,
                           wdata: req0_wdata, pc: req0_pc, port: 1'b0};
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign req0_ready = reset & (state == IDLE) & ~grant;
  assign req1_ready = reset & (state == IDLE) &  grant;
  assign hs = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant  <= RR_INIT;
      lat         <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (hs) begin
        last_grant <= grant;
        lat        <= req_sel;
      end
      if (state == ACCESS) begin
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= (lat.we || acc_err) ? '0 : dm_rdata;
      end
    end
  end

  always_comb begin
    dm_we      = 1'b0;
    dm_op      = '0;
    dm_a       = '0;
    dm_wdata   = '0;
    dm_pc      = '0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_rdata = '0;
    rsp1_rdata = '0;
    rsp0_err   = 1'b0;
    rsp1_err   = 1'b0;
    if (state == ACCESS) begin
      dm_we    = lat.we & ~acc_err;
      dm_op    = lat.op;
      dm_a     = lat.addr;
      dm_wdata = lat.wdata;
      dm_pc    = lat.pc;
    end
    if (state == RESP) begin
      if (lat.port) begin
        rsp1_valid = 1'b1;
        rsp1_rdata = rsp_rdata_q;
        rsp1_err   = rsp_err_q;
      end else begin
        rsp0_valid = 1'b1;
        rsp0_rdata = rsp_rdata_q;
        rsp0_err   = rsp_err_q;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed-vector bench for dm_arbiter with a byte-addressed memory model.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [1:0]  req0_op = '0;
  logic [31:0] req0_addr = '0, req0_wdata = '0, req0_pc = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [1:0]  req1_op = '0;
  logic [31:0] req1_addr = '0, req1_wdata = '0, req1_pc = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        dm_we;
  logic [1:0]  dm_op;
  logic [31:0] dm_a, dm_wdata, dm_pc, dm_rdata;

  int n_vec = 0;
  int n_err = 0;
  int gp[4];
  int gc[4];
  int ng;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_LIMIT(32'h0000_1000), .RR_INIT(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_op(req0_op), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_pc(req0_pc), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_op(req1_op), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_pc(req1_pc), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_err(rsp1_err),
    .dm_we(dm_we), .dm_op(dm_op), .dm_a(dm_a), .dm_wdata(dm_wdata),
    .dm_pc(dm_pc), .dm_rdata(dm_rdata)
  );

  // Little-endian byte memory; loads are sign-extended here, as the real memory does.
  logic [7:0]  mem [0:4095];
  logic [11:0] ix;
  assign ix = dm_a[11:0];

  initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (dm_we) begin
      case (dm_op)
        2'b00: begin
          mem[ix] <= dm_wdata[7:0];          mem[ix + 12'd1] <= dm_wdata[15:8];
          mem[ix + 12'd2] <= dm_wdata[23:16]; mem[ix + 12'd3] <= dm_wdata[31:24];
        end
        2'b01: mem[ix] <= dm_wdata[7:0];
        2'b10: begin mem[ix] <= dm_wdata[7:0]; mem[ix + 12'd1] <= dm_wdata[15:8]; end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (dm_op)
      2'b00:   dm_rdata = {mem[ix + 12'd3], mem[ix + 12'd2], mem[ix + 12'd1], mem[ix]};
      2'b01:   dm_rdata = {{24{mem[ix][7]}}, mem[ix]};
      2'b10:   dm_rdata = {{16{mem[ix + 12'd1][7]}}, mem[ix + 12'd1], mem[ix]};
      default: dm_rdata = '0;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic we, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_op = op; req0_addr = a; req0_wdata = d; req0_pc = pc;
    end else begin
      req1_valid = v; req1_we = we; req1_op = op; req1_addr = a; req1_wdata = d; req1_pc = pc;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; #1;
  endtask

  // One complete transaction: handshake, ACCESS cycle, RESP cycle.
  task automatic do_req(input string tag, input int p, input logic we, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc,
                        input logic exp_we, input logic [31:0] exp_rdata, input logic exp_err);
    logic got;
    @(negedge clk);
    set_req(p, 1'b1, we, op, a, d, pc); #1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rdy(p)) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    check_val({tag, "_hs"}, {31'd0, got}, 32'd1);
    if (!got) begin set_req(p, 1'b0, 1'b0, 2'b00, 0, 0, 0); return; end
    @(negedge clk);
    set_req(p, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    check_val({tag, "_dm_we"}, {31'd0, dm_we}, {31'd0, exp_we});
    check_val({tag, "_dm_a"}, dm_a, a);
    check_val({tag, "_dm_op"}, {30'd0, dm_op}, {30'd0, op});
    check_val({tag, "_dm_wdata"}, dm_wdata, d);
    check_val({tag, "_dm_pc"}, dm_pc, pc);
    check_val({tag, "_rdy_acc"}, {30'd0, req0_ready, req1_ready}, 32'd0);
    @(negedge clk);
    check_val({tag, "_rsp_v"}, {30'd0, rsp1_valid, rsp0_valid}, (p == 0) ? 32'd1 : 32'd2);
    check_val({tag, "_rdata"}, (p == 0) ? rsp0_rdata : rsp1_rdata, exp_rdata);
    check_val({tag, "_err"}, {31'd0, (p == 0) ? rsp0_err : rsp1_err}, {31'd0, exp_err});
    check_val({tag, "_dm_idle"}, {dm_a[30:0], dm_we}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    check_val("rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    check_val("rst_dm", {dm_a[30:0], dm_we}, 32'd0);
    reset = 1'b1; #1;
    check_val("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
    check_val("post_rst_ready1", {31'd0, req1_ready}, 32'd0);

    do_req("st_word",   0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h100, 1'b1, 32'h0, 1'b0);
    do_req("ld_word",   0, 1'b0, 2'b00, 32'h10, 32'h0, 32'h104, 1'b0, 32'hDEADBEEF, 1'b0);
    do_req("ld_half_mis", 1, 1'b0, 2'b10, 32'h13, 32'h0, 32'h200, 1'b0, 32'h0, 1'b1);
    do_req("st_byte",   0, 1'b1, 2'b01, 32'h21, 32'h80, 32'h108, 1'b1, 32'h0, 1'b0);
    do_req("ld_byte",   1, 1'b0, 2'b01, 32'h21, 32'h0, 32'h204, 1'b0, 32'hFFFFFF80, 1'b0);
    do_req("ld_half",   0, 1'b0, 2'b10, 32'h20, 32'h0, 32'h10C, 1'b0, 32'hFFFF8000, 1'b0);
    do_req("st_w0",     1, 1'b1, 2'b00, 32'h0, 32'h12345678, 32'h208, 1'b1, 32'h0, 1'b0);
    do_req("st_oor",    0, 1'b1, 2'b00, 32'h1000, 32'hCAFEF00D, 32'h110, 1'b0, 32'h0, 1'b1);
    do_req("ld_w0",     0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h114, 1'b0, 32'h12345678, 1'b0);
    do_req("ld_ill",    1, 1'b0, 2'b11, 32'h8, 32'h0, 32'h20C, 1'b0, 32'h0, 1'b1);
    do_req("ld_word_mis", 0, 1'b0, 2'b00, 32'h12, 32'h0, 32'h118, 1'b0, 32'h0, 1'b1);
    do_req("st_half",   1, 1'b1, 2'b10, 32'h1E, 32'h0000ABCD, 32'h210, 1'b1, 32'h0, 1'b0);
    do_req("ld_half2",  0, 1'b0, 2'b10, 32'h1E, 32'h0, 32'h11C, 1'b0, 32'hFFFFABCD, 1'b0);

    // Reset during the ACCESS cycle of a store aborts it.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 2'b00, 32'h40, 32'h55, 32'h300); #1;
    check_val("abort_hs", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    check_val("abort_we_pre", {31'd0, dm_we}, 32'd1);
    reset = 1'b0; #1;
    check_val("abort_we_drop", {31'd0, dm_we}, 32'd0);
    check_val("abort_dm_a", dm_a, 32'd0);
    set_req(0, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    @(negedge clk);
    check_val("abort_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    reset = 1'b1;
    set_req(0, 1'b1, 1'b0, 2'b00, 32'h40, 32'h0, 32'h304);
    set_req(1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h404); #1;
    check_val("after_rst_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    set_req(1, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    @(negedge clk);
    check_val("after_rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    check_val("aborted_no_write", rsp0_rdata, 32'h0);

    // Both ports held valid: grants alternate, three cycles apart.
    pulse_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 2'b00, 32'h10, 0, 32'h500);
    set_req(1, 1'b1, 1'b0, 2'b00, 32'h0, 0, 32'h600); #1;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      if (req0_ready)      begin gp[ng] = 0; gc[ng] = cyc; ng++; end
      else if (req1_ready) begin gp[ng] = 1; gc[ng] = cyc; ng++; end
      if (ng < 4) begin @(negedge clk); #1; end
    end
    check_val("rr_count", ng, 4);
    if (ng == 4) begin
      for (int i = 0; i < 4; i++) check_val($sformatf("rr_port%0d", i), gp[i], i % 2);
      for (int i = 0; i < 3; i++) check_val($sformatf("rr_gap%0d", i), gc[i+1] - gc[i], 3);
    end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    set_req(1, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    repeat (2) @(negedge clk);

    // Port 1 withdraws its store before it is granted; nothing reaches memory.
    pulse_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 2'b00, 32'h10, 0, 32'h700);
    set_req(1, 1'b1, 1'b1, 2'b00, 32'h30, 32'hAAAA5555, 32'h800); #1;
    check_val("drop_tie", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    set_req(1, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    @(negedge clk);
    check_val("drop_rsp0", rsp0_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("drop_quiet%0d", i), {dm_a[29:0], dm_we, rsp1_valid}, 32'd0);
    end
    do_req("drop_ld", 0, 1'b0, 2'b00, 32'h30, 32'h0, 32'h704, 1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
